gm_dither: RTL and testbench
============================

# gm_dither

Output quantiser placed directly after the gamma curve stage. It takes the 8.2 fixed-point gamma-corrected pixel stream and reduces it to an 8-bit integer. It supports rounding, horizontal 1-D error diffusion, and a 2x2 spatio-temporal ordered dither. Mode and enable are shadowed at frame start, and line/column/frame position is tracked internally from the valid strobe.

## Interface
- DAT_SZ, 8, integer bits of input and output width; input carries 2 extra fraction bits (FRAC_SZ = 2, fixed)
- pclk  in  1  pixel clock
- prst  in  1  synchronous, active-high reset (pclk domain)
- px_i  in  DAT_SZ+2  gamma-corrected pixel, unsigned DAT_SZ.2
- px_vld_i  in  1  high on active pixels of a line; low in blanking
- frm_str_i  in  1  one-cycle pulse at frame start, before the first line
- dith_en  in  1  dither enable (register value, shadowed)
- dith_mode  in  2  0 round, 1 error diffusion, 2 ordered, 3 reserved (acts as 0); shadowed
- px_o  out  DAT_SZ  quantised pixel
- px_vld_o  out  1  px_vld_i delayed 1 cycle

## Operation
- Shadow registers en_s and mode_s load dith_en/dith_mode only on cycles with frm_str_i = 1. Otherwise they hold. Reset value is 0/0.
- Position state:
  - frm_par toggles on each frm_str_i.
  - row_par clears on frm_str_i and toggles on each px_vld_i falling edge (vld_q & ~px_vld_i).
  - col_par clears when px_vld_i = 0 and toggles on every valid pixel.
- Error register err[1:0] clears on frm_str_i, clears while px_vld_i = 0, and updates only on valid pixels. The first pixel of every line therefore sees err = 0.
- Per valid pixel, with sum width DAT_SZ+3:
  - en_s = 0, or mode 0/3: sum = px_i + 2.
  - Mode 1: sum = px_i + err. Next err = sum[1:0].
  - Mode 2: sum = px_i + ofs. ofs comes from Bayer B = {B00 = 0, B01 = 2, B10 = 3, B11 = 1}, indexed {row_par^frm_par, col_par^frm_par}.
- Output: q = sum[DAT_SZ+2:2]. If q > 2^DAT_SZ-1, px_o = all ones (saturate) and next err = 0 in mode 1. Otherwise px_o = q[DAT_SZ-1:0].
- Non-valid cycles: px_o holds its previous value and err is cleared.
- frm_str_i coincident with px_vld_i = 1: the shadow load, parity clears and err clear take effect first. That pixel is processed with the new mode, err = 0, row_par = 0, col_par = 0, and the new frm_par.

## Timing
- Latency is 1 cycle from px_i/px_vld_i to px_o/px_vld_o. There is no stall or backpressure; every cycle is accepted.
- Error feedback is single-cycle: the err used for pixel n+1 is produced by pixel n.
- Reset values: px_o = 0, px_vld_o = 0, err = 0, all parities 0, en_s = 0, mode_s = 0.
- prst mid-line has immediate effect on the next edge. Following pixels start a fresh line position (col_par = 0, err = 0). The mode stays 0 until the next frm_str_i.
- A dith_mode/dith_en change mid-frame has no effect until the next frm_str_i.

## Structure
- Shared package gm_pkg holds:
  - mode encodings GM_DITH_RND, GM_DITH_ED, GM_DITH_ORD;
  - FRAC_SZ = 2;
  - the 2x2 Bayer constants;
  - the round constant 2.
- Optional sub-module gm_dith_pos: frm/row/col parity tracker driven by px_vld_i and frm_str_i. The quantiser datapath stays in gm_dither.

## Test plan
- Round (en = 1, mode 0): px_i = 0x3FE -> px_o = 0xFF (saturated). px_i = 0x005 -> px_o = 0x01. px_i = 0x006 -> px_o = 0x02.
- Error diffusion (mode 1): 8 valid pixels at px_i = 0x001 -> px_o = 0,0,0,1,0,0,0,1. px_vld_o follows one cycle late.
- ED line reset: a line ends with err = 3, then 2 blanking cycles, then the next line starts at px_i = 0x001 -> first px_o = 0 (err restarted at 0).
- Ordered (mode 2): px_i = 0x002 constant.
  - Frame A: row 0 -> 0,1,0,1; row 1 -> 1,0,1,0.
  - After the next frm_str_i: row 0 -> 0,1,0,1 with the offsets swapped to 1,3. Check the sums 3,5 -> 0,1.
- Shadow: set mode 1 mid-frame -> output still follows mode 0 until frm_str_i. A frm_str_i coincident with the first valid pixel -> that pixel already uses mode 1.
- Reset mid-line: assert prst for 1 cycle during a mode-1 line -> next cycle px_o = 0, px_vld_o = 0. Subsequent pixels are rounded (mode 0) until a frm_str_i.

Source files
------------

// File: rtl/gm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gm_pkg : shared constants for the gamma output quantiser          |
// | Rev 1.0 : initial release                                         |
// +------------------------------------------------------------------+
package gm_pkg;

  localparam int FRAC_SZ = 2;

  typedef logic [1:0] gm_mode_t;

  localparam gm_mode_t GM_DITH_RND = 2'd0;
  localparam gm_mode_t GM_DITH_ED  = 2'd1;
  localparam gm_mode_t GM_DITH_ORD = 2'd2;

  localparam logic [1:0] GM_RND_C    = 2'd2;

  localparam logic [1:0] GM_BAYER_00 = 2'd0;
  localparam logic [1:0] GM_BAYER_01 = 2'd2;
  localparam logic [1:0] GM_BAYER_10 = 2'd3;
  localparam logic [1:0] GM_BAYER_11 = 2'd1;

  // 2x2 Bayer lookup indexed by {row, col}
  function automatic logic [1:0] gm_bayer(input logic row, input logic col);
    logic [1:0] ofs;
    case ({row, col})
      2'b00:   ofs = GM_BAYER_00;
      2'b01:   ofs = GM_BAYER_01;
      2'b10:   ofs = GM_BAYER_10;
      default: ofs = GM_BAYER_11;
    endcase
    return ofs;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gm_dith_pos.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gm_dith_pos : frame/row/column parity tracker from valid strobe   |
// | Rev 1.0 : initial release                                         |
// +------------------------------------------------------------------+
module gm_dith_pos
  import gm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_vld,
  input  logic i_frm_str,
  output logic o_frm_par,
  output logic o_row_par,
  output logic o_col_par,
  output logic o_vld_q
);

  logic r_frm_par;
  logic r_row_par;
  logic r_col_par;
  logic r_vld_q;
  logic w_line_end;

  // Outputs are the parities seen by the pixel on this cycle, so a
  // coincident frame start already applies its clears and toggle.
  assign o_frm_par  = i_frm_str ? ~r_frm_par : r_frm_par;
  assign o_row_par  = i_frm_str ? 1'b0 : r_row_par;
  assign o_col_par  = i_frm_str ? 1'b0 : r_col_par;
  assign o_vld_q    = r_vld_q;
  assign w_line_end = r_vld_q & ~i_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frm_par <= 1'b0;
      r_row_par <= 1'b0;
      r_col_par <= 1'b0;
      r_vld_q   <= 1'b0;
    end else begin
      r_vld_q   <= i_vld;
      r_frm_par <= o_frm_par;
      if (i_frm_str) begin
        r_row_par <= 1'b0;
      end else if (w_line_end) begin
        r_row_par <= ~r_row_par;
      end
      r_col_par <= i_vld ? ~o_col_par : 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gm_dither.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gm_dither : 8.2 -> 8 bit quantiser (round / error diff / ordered)  |
// | Rev 1.0 : initial release                                         |
// +------------------------------------------------------------------+
module gm_dither
  import gm_pkg::*;
#(
  parameter int DAT_SZ = 8
) (
  input  logic                      pclk,
  input  logic                      prst,
  input  logic [DAT_SZ+FRAC_SZ-1:0] px_i,
  input  logic                      px_vld_i,
  input  logic                      frm_str_i,
  input  logic                      dith_en,
  input  logic [1:0]                dith_mode,
  output logic [DAT_SZ-1:0]         px_o,
  output logic                      px_vld_o
);

  localparam int SUM_W = DAT_SZ + FRAC_SZ + 1;

  logic                r_en_s;
  gm_mode_t            r_mode_s;
  logic [FRAC_SZ-1:0]  r_err;
  logic [DAT_SZ-1:0]   r_px;

  logic                w_en;
  gm_mode_t            w_mode;
  logic [FRAC_SZ-1:0]  w_err;
  logic                w_frm_par;
  logic                w_row_par;
  logic                w_col_par;
  logic                w_vld_q;
  logic [FRAC_SZ-1:0]  w_ofs;
  logic [SUM_W-1:0]    w_sum;
  logic [DAT_SZ:0]     w_q;
  logic                w_sat;
  logic [DAT_SZ-1:0]   w_px;
  logic [FRAC_SZ-1:0]  w_err_nxt;

  gm_dith_pos u_pos (
    .clk       (pclk),
    .rst       (prst),
    .i_vld     (px_vld_i),
    .i_frm_str (frm_str_i),
    .o_frm_par (w_frm_par),
    .o_row_par (w_row_par),
    .o_col_par (w_col_par),
    .o_vld_q   (w_vld_q)
  );

  // A frame start coincident with a pixel must already steer that pixel.
  assign w_en   = frm_str_i ? dith_en   : r_en_s;
  assign w_mode = frm_str_i ? dith_mode : r_mode_s;
  assign w_err  = frm_str_i ? '0        : r_err;

  always_comb begin
    w_ofs = GM_RND_C;
    if (w_en) begin
      case (w_mode)
        GM_DITH_ED:  w_ofs = w_err;
        GM_DITH_ORD: w_ofs = gm_bayer(w_row_par ^ w_frm_par, w_col_par ^ w_frm_par);
        default:     w_ofs = GM_RND_C;
      endcase
    end
  end

  assign w_sum = SUM_W'(px_i) + SUM_W'(w_ofs);
  assign w_q   = w_sum[SUM_W-1:FRAC_SZ];
  assign w_sat = w_q[DAT_SZ];
  assign w_px  = w_sat ? {DAT_SZ{1'b1}} : w_q[DAT_SZ-1:0];

  // Residue is only carried in error-diffusion mode and dropped on clipping.
  assign w_err_nxt = (px_vld_i && w_en && (w_mode == GM_DITH_ED) && !w_sat)
                     ? w_sum[FRAC_SZ-1:0] : '0;

  always_ff @(posedge pclk) begin
    if (prst) begin
      r_en_s   <= 1'b0;
      r_mode_s <= GM_DITH_RND;
      r_err    <= '0;
      r_px     <= '0;
    end else begin
      if (frm_str_i) begin
        r_en_s   <= dith_en;
        r_mode_s <= dith_mode;
      end
      r_err <= w_err_nxt;
      if (px_vld_i) begin
        r_px <= w_px;
      end
    end
  end

  assign px_o     = r_px;
  assign px_vld_o = w_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_gm_dither.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_gm_dither : scoreboard bench for the gm_dither quantiser        |
// | Rev 1.0 : initial release                                         |
// +------------------------------------------------------------------+
module tb_gm_dither;

  logic       pclk = 1'b0;
  logic       prst = 1'b1;
  logic [9:0] px_i = '0;
  logic       px_vld_i = 1'b0;
  logic       frm_str_i = 1'b0;
  logic       dith_en = 1'b0;
  logic [1:0] dith_mode = 2'd0;
  logic [7:0] px_o;
  logic       px_vld_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [7:0] px;
    logic       vld;
  } exp_t;
  exp_t q_exp[$];

  // reference state
  logic       m_en, m_frm, m_row, m_col, m_vq;
  logic [1:0] m_mode;
  int         m_err;
  logic [7:0] m_px;
  int         bay[4] = '{0, 2, 3, 1};

  gm_dither #(.DAT_SZ(8)) dut (
    .pclk      (pclk),
    .prst      (prst),
    .px_i      (px_i),
    .px_vld_i  (px_vld_i),
    .frm_str_i (frm_str_i),
    .dith_en   (dith_en),
    .dith_mode (dith_mode),
    .px_o      (px_o),
    .px_vld_o  (px_vld_o)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: apply inputs, advance the model, push, then compare
  task automatic drive(input logic vld, input logic [9:0] px, input logic fs, input logic rs);
    int   ofs, s, q;
    exp_t e;
    @(negedge pclk);
    prst = rs; px_vld_i = vld; px_i = px; frm_str_i = fs;
    if (rs) begin
      m_en = 0; m_mode = 0; m_err = 0; m_frm = 0; m_row = 0; m_col = 0; m_vq = 0; m_px = 0;
    end else begin
      if (fs) begin
        m_en = dith_en; m_mode = dith_mode; m_err = 0; m_frm = ~m_frm; m_row = 0; m_col = 0;
      end
      if (vld) begin
        if (m_en && m_mode == 2'd1)      ofs = m_err;
        else if (m_en && m_mode == 2'd2) ofs = bay[{m_row ^ m_frm, m_col ^ m_frm}];
        else                             ofs = 2;
        s = int'(px) + ofs;
        q = s / 4;
        m_px  = (q > 255) ? 8'hFF : 8'(q);
        m_err = (m_en && m_mode == 2'd1 && q <= 255) ? (s % 4) : 0;
        m_col = ~m_col;
      end else begin
        m_err = 0;
        m_col = 0;
        if (m_vq && !fs) m_row = ~m_row;
      end
      m_vq = vld;
    end
    e.px = m_px; e.vld = m_vq;
    q_exp.push_back(e);
    @(posedge pclk);
    #1;
    if (q_exp.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = q_exp.pop_front();
      chk("sb_px", 32'(px_o), 32'(e.px));
      chk("sb_vld", 32'(px_vld_o), 32'(e.vld));
    end
  endtask

  task automatic pix(input logic [9:0] px);
    drive(1'b1, px, 1'b0, 1'b0);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 10'h0, 1'b0, 1'b0);
  endtask

  task automatic frame(input logic en, input logic [1:0] md);
    dith_en = en; dith_mode = md;
    drive(1'b0, 10'h0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] ed_exp [8] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    logic [7:0] ord_r0 [4] = '{8'd0, 8'd1, 8'd0, 8'd1};
    logic [7:0] ord_r1 [4] = '{8'd1, 8'd0, 8'd1, 8'd0};

    drive(1'b0, 10'h0, 1'b0, 1'b1);
    drive(1'b1, 10'h3FF, 1'b0, 1'b1);
    chk("rst_px", 32'(px_o), 32'h0);
    chk("rst_vld", 32'(px_vld_o), 32'h0);
    blank(2);

    // rounding
    frame(1'b1, 2'd0);
    pix(10'h3FE); chk("rnd_sat", 32'(px_o), 32'hFF);
    pix(10'h005); chk("rnd_5", 32'(px_o), 32'h01);
    pix(10'h006); chk("rnd_6", 32'(px_o), 32'h02);
    blank(2);

    // error diffusion
    frame(1'b1, 2'd1);
    for (int i = 0; i < 8; i++) begin
      pix(10'h001);
      chk("ed_seq", 32'(px_o), 32'(ed_exp[i]));
      chk("ed_vld", 32'(px_vld_o), 32'h1);
    end
    blank(1);
    chk("ed_vld_lo", 32'(px_vld_o), 32'h0);
    blank(1);
    pix(10'h001); pix(10'h001); pix(10'h001);
    blank(2);
    pix(10'h001); chk("ed_line_rst", 32'(px_o), 32'h0);
    blank(2);
    pix(10'h3FF); chk("ed_nosat", 32'(px_o), 32'hFF);
    pix(10'h3FF); chk("ed_sat", 32'(px_o), 32'hFF);
    pix(10'h002); chk("ed_sat_clr", 32'(px_o), 32'h0);
    blank(2);

    // ordered: two frame starts so frame parity returns to 0
    frame(1'b1, 2'd2);
    blank(1);
    frame(1'b1, 2'd2);
    for (int i = 0; i < 4; i++) begin pix(10'h002); chk("ord_a_r0", 32'(px_o), 32'(ord_r0[i])); end
    blank(2);
    for (int i = 0; i < 4; i++) begin pix(10'h002); chk("ord_a_r1", 32'(px_o), 32'(ord_r1[i])); end
    blank(2);
    frame(1'b1, 2'd2);
    for (int i = 0; i < 4; i++) begin pix(10'h002); chk("ord_b_r0", 32'(px_o), 32'(ord_r0[i])); end
    blank(2);

    // shadowing
    frame(1'b1, 2'd0);
    pix(10'h001);
    dith_mode = 2'd1;
    pix(10'h001); pix(10'h001); pix(10'h001);
    chk("shadow_hold", 32'(px_o), 32'h0);
    pix(10'h002); chk("shadow_rnd", 32'(px_o), 32'h1);
    blank(2);
    drive(1'b1, 10'h003, 1'b1, 1'b0);
    chk("fs_coinc0", 32'(px_o), 32'h0);
    pix(10'h001); chk("fs_coinc1", 32'(px_o), 32'h1);
    blank(2);

    // reset mid-line
    pix(10'h001); pix(10'h001);
    drive(1'b1, 10'h001, 1'b0, 1'b1);
    chk("mid_rst_px", 32'(px_o), 32'h0);
    chk("mid_rst_vld", 32'(px_vld_o), 32'h0);
    for (int i = 0; i < 4; i++) begin pix(10'h002); chk("post_rst_rnd", 32'(px_o), 32'h1); end
    blank(1);
    frame(1'b1, 2'd1);
    pix(10'h002); chk("post_rst_ed", 32'(px_o), 32'h0);
    blank(2);

    // randomised traffic checked by the scoreboard
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        dith_en = 1'($urandom_range(0, 1));
        dith_mode = 2'($urandom_range(0, 3));
      end
      drive(($urandom_range(0, 3) != 0), 10'($urandom_range(0, 1023)),
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 127) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
